alu_share_ctrl: RTL and testbench

Controller that shares one pipelined 4-bit ALU between two independent requesters. It arbitrates round-robin between the requesters and issues each granted operation to the ALU. It tracks in-flight operations by requester tag and returns each result to its originator through a per-requester response FIFO with valid/ready flow control. It sits between the stimulus/driver agents and the ALU DUT, and feeds the monitor, scoreboard and checker path.

---
 rtl/alu_share_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// =============================================================================
// alu_share_ctrl : round-robin sharing of one pipelined ALU by two requesters,
//                  results returned through credit-gated per-requester FIFOs
// Revision: 1.0
// =============================================================================
module alu_share_ctrl #(
  parameter int DATA_W      = 4,
  parameter int OP_W        = 3,
  parameter int ALU_LATENCY = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W:0]   alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W:0]   rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W:0]   rsp1_data,
  output logic              busy
);

  localparam int c_CRED_W = $clog2(RSP_DEPTH + 1);
  localparam int c_PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [1:0]        w_req_valid;
  logic [OP_W-1:0]   w_req_op [2];
  logic [DATA_W-1:0] w_req_a  [2];
  logic [DATA_W-1:0] w_req_b  [2];
  logic [1:0]        w_rsp_ready;
  logic [1:0]        w_rsp_valid;
  logic [DATA_W:0]   w_rsp_data [2];
  logic [1:0]        w_elig;
  logic [1:0]        w_grant;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic              w_sel;

  logic              r_last_grant;
  logic              r_alu_start;
  logic              r_alu_id;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [ALU_LATENCY-1:0] r_tag_v;
  logic [ALU_LATENCY-1:0] r_tag_id;

  assign w_req_valid = {r1_valid, r0_valid};
  assign w_req_op[0] = r0_op;
  assign w_req_op[1] = r1_op;
  assign w_req_a[0]  = r0_a;
  assign w_req_a[1]  = r1_a;
  assign w_req_b[0]  = r0_b;
  assign w_req_b[1]  = r1_b;
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Grant is a function of registered credits only, so a freed credit waits a cycle
  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  assign w_sel    = w_grant[1];
  assign r0_ready = w_grant[0];
  assign r1_ready = w_grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_start  <= 1'b0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_alu_start <= |w_grant;
      if (|w_grant) begin
        r_alu_op     <= w_req_op[w_sel];
        r_alu_a      <= w_req_a[w_sel];
        r_alu_b      <= w_req_b[w_sel];
        r_alu_id     <= w_sel;
        r_last_grant <= w_sel;
      end
    end
  end

  // Stage k holds the tag of the op issued k+1 cycles ago; last stage aligns with alu_result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= r_alu_start;
      r_tag_id[0] <= r_alu_id;
      for (int k = 1; k < ALU_LATENCY; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [DATA_W:0]     r_mem [RSP_DEPTH];
    logic [c_PTR_W-1:0]  r_rd;
    logic [c_PTR_W-1:0]  r_wr;
    logic [c_CRED_W-1:0] r_cnt;
    logic [c_CRED_W-1:0] r_credit;
    logic                w_full;

    assign w_full          = (r_cnt == c_CRED_W'(RSP_DEPTH));
    assign w_elig[gi]      = w_req_valid[gi] && (r_credit < c_CRED_W'(RSP_DEPTH));
    assign w_push[gi]      = r_tag_v[ALU_LATENCY-1] && (r_tag_id[ALU_LATENCY-1] == 1'(gi));
    assign w_rsp_valid[gi] = (r_cnt != '0);
    assign w_pop[gi]       = w_rsp_valid[gi] && w_rsp_ready[gi];
    assign w_rsp_data[gi]  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < RSP_DEPTH; k++) begin
          r_mem[k] <= '0;
        end
        r_rd     <= '0;
        r_wr     <= '0;
        r_cnt    <= '0;
        r_credit <= '0;
      end else begin
        // On a full FIFO with push+pop the write lands in the slot being vacated
        if (w_push[gi]) begin
          r_mem[r_wr] <= alu_result;
          r_wr        <= f_ptr_next(r_wr);
        end
        if (w_pop[gi]) begin
          r_rd <= f_ptr_next(r_rd);
        end
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_cnt <= r_cnt + c_CRED_W'(1);
          2'b01:   r_cnt <= r_cnt - c_CRED_W'(1);
          default: r_cnt <= r_cnt;
        endcase
        case ({w_grant[gi], w_pop[gi]})
          2'b10:   r_credit <= r_credit + c_CRED_W'(1);
          2'b01:   r_credit <= r_credit - c_CRED_W'(1);
          default: r_credit <= r_credit;
        endcase
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push[gi] && w_full && !w_pop[gi]));
  end

  assign alu_start  = r_alu_start;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_data  = w_rsp_data[0];
  assign rsp1_data  = w_rsp_data[1];
  assign busy       = (|r_tag_v) | (|w_rsp_valid) | r_alu_start;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// Bench for alu_share_ctrl: behavioural ALU plus transaction-level model of
// grants, per-requester result queues, response timing and busy.
module tb_alu_share_ctrl;

  localparam int L = 1;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0_valid = 0, r1_valid = 0;
  logic       r0_ready, r1_ready;
  logic [2:0] r0_op = 0, r1_op = 0;
  logic [3:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic       alu_start;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_result;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 0, rsp1_ready = 0;
  logic [4:0] rsp0_data, rsp1_data;
  logic       busy;

  alu_share_ctrl #(.DATA_W(4), .OP_W(3), .ALU_LATENCY(L), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return {1'b0, ~a};
      default: return {1'b0, b};
    endcase
  endfunction

  // Behavioural ALU with L cycles of latency
  logic [4:0] alu_pipe [L];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_start ? alu_f(alu_op, alu_a, alu_b) : 5'h00;
    for (int k = 1; k < L; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_result = alu_pipe[L-1];

  typedef struct {
    logic [4:0] d;
    int         vis;
    int         hs;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int         cyc = 0;
  logic       m_last = 1'b1;
  logic       m_start = 1'b0;
  logic [2:0] m_op = 0;
  logic [3:0] m_a = 0, m_b = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] s_rdy, s_rv;
  logic       s_start;
  logic [3:0] s_a, s_b;
  logic [4:0] s_rd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    r0_valid = 0; r1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("rst_alu_start", 32'(alu_start), 0);
    chk("rst_alu_op",    32'(alu_op), 0);
    chk("rst_alu_a",     32'(alu_a), 0);
    chk("rst_alu_b",     32'(alu_b), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp0_data", 32'(rsp0_data), 0);
    chk("rst_rsp1_data", 32'(rsp1_data), 0);
    chk("rst_busy",      32'(busy), 0);
    q0.delete(); q1.delete();
    m_last = 1'b1; m_start = 1'b0; m_op = 0; m_a = 0; m_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v0, input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic v1, input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                      input logic rr0, input logic rr1);
    logic [1:0] el, g;
    logic       ev0, ev1, eb;
    ent_t       e;
    @(negedge clk);
    r0_valid = v0; r0_op = o0; r0_a = a0; r0_b = b0;
    r1_valid = v1; r1_op = o1; r1_a = a1; r1_b = b1;
    rsp0_ready = rr0; rsp1_ready = rr1;
    #1;
    el[0] = v0 && (q0.size() < D);
    el[1] = v1 && (q1.size() < D);
    g = (el == 2'b11) ? (m_last ? 2'b01 : 2'b10) : el;
    ev0 = (q0.size() > 0) && (q0[0].vis <= cyc);
    ev1 = (q1.size() > 0) && (q1[0].vis <= cyc);
    eb = 1'b0;
    foreach (q0[k]) if (q0[k].hs < cyc) eb = 1'b1;
    foreach (q1[k]) if (q1[k].hs < cyc) eb = 1'b1;
    chk("r0_ready",   32'(r0_ready), 32'(g[0]));
    chk("r1_ready",   32'(r1_ready), 32'(g[1]));
    chk("alu_start",  32'(alu_start), 32'(m_start));
    chk("alu_op",     32'(alu_op), 32'(m_op));
    chk("alu_a",      32'(alu_a), 32'(m_a));
    chk("alu_b",      32'(alu_b), 32'(m_b));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (ev0) chk("rsp0_data", 32'(rsp0_data), 32'(q0[0].d));
    if (ev1) chk("rsp1_data", 32'(rsp1_data), 32'(q1[0].d));
    chk("busy", 32'(busy), 32'(eb));
    s_rdy = {r1_ready, r0_ready}; s_rv = {rsp1_valid, rsp0_valid};
    s_start = alu_start; s_a = alu_a; s_b = alu_b; s_rd0 = rsp0_data;
    if (ev0 && rr0) void'(q0.pop_front());
    if (ev1 && rr1) void'(q1.pop_front());
    m_start = |g;
    if (g[0]) begin
      m_last = 1'b0; m_op = o0; m_a = a0; m_b = b0;
      e.d = alu_f(o0, a0, b0); e.vis = cyc + L + 2; e.hs = cyc;
      q0.push_back(e);
    end else if (g[1]) begin
      m_last = 1'b1; m_op = o1; m_a = a1; m_b = b1;
      e.d = alu_f(o1, a1, b1); e.vis = cyc + L + 2; e.hs = cyc;
      q1.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input logic rr0, input logic rr1);
    step(0, 0, 0, 0, 0, 0, 0, 0, rr0, rr1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hs0, hs1, p0, p1;
    do_reset();

    // Single ADD 9+8 from requester 0
    step(1, 3'd0, 4'h9, 4'h8, 0, 0, 0, 0, 0, 0);
    chk("single_ready", 32'(s_rdy[0]), 1);
    idle(0, 0);
    chk("single_start", 32'(s_start), 1);
    chk("single_a", 32'(s_a), 9);
    chk("single_b", 32'(s_b), 8);
    for (int k = 0; k < L; k++) idle(0, 0);
    idle(1, 0);
    chk("single_rsp_valid", 32'(s_rv[0]), 1);
    chk("single_rsp_data", 32'(s_rd0), 32'h11);
    for (int k = 0; k < 3; k++) idle(1, 1);

    // Contention: alternating grants beginning with requester 0
    do_reset();
    p0 = 0; p1 = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 3'(k), 4'(k), 4'(k + 3), 1, 3'(k + 1), 4'(k + 7), 4'(k), 1, 1);
      chk("cont_grant0", 32'(s_rdy[0]), 32'((k % 2) == 0));
      chk("cont_grant1", 32'(s_rdy[1]), 32'((k % 2) == 1));
      p0 += int'(s_rv[0]); p1 += int'(s_rv[1]);
    end
    for (int k = 0; k < 12; k++) begin
      idle(1, 1);
      p0 += int'(s_rv[0]); p1 += int'(s_rv[1]);
    end
    chk("cont_rsp0_count", 32'(p0), 4);
    chk("cont_rsp1_count", 32'(p1), 4);

    // Backpressure on FIFO 0, then one pop releases exactly one more issue
    do_reset();
    hs0 = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 3'd2, 4'(k), 4'hF, 0, 0, 0, 0, 0, 0);
      hs0 += int'(s_rdy[0]);
    end
    chk("bp_issues", 32'(hs0), 2);
    chk("bp_stalled", 32'(s_rdy[0]), 0);
    step(1, 3'd3, 4'h5, 4'hA, 0, 0, 0, 0, 1, 0);
    chk("bp_pop_cycle_ready", 32'(s_rdy[0]), 0);
    step(1, 3'd3, 4'h5, 4'hA, 0, 0, 0, 0, 0, 0);
    chk("bp_after_pop_ready", 32'(s_rdy[0]), 1);
    hs0 = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, 3'd4, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0);
      hs0 += int'(s_rdy[0]);
    end
    chk("bp_no_more", 32'(hs0), 0);

    // Isolation: FIFO 0 stalled, requester 1 streams
    hs0 = 0; hs1 = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 3'd0, 4'h3, 4'h3, 1, 3'(k), 4'(3 * k), 4'(k + 9), 0, 1);
      hs0 += int'(s_rdy[0]); hs1 += int'(s_rdy[1]);
    end
    chk("iso_r0_blocked", 32'(hs0), 0);
    chk("iso_r1_issues", 32'(hs1), 4);
    for (int k = 0; k < 8; k++) idle(1, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 7, 3'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 10; k++) idle(1, 1);
    chk("drain_busy", 32'(busy), 0);

    // Reset with two operations in flight
    step(1, 3'd0, 4'h7, 4'h7, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 3'd1, 4'h2, 4'h9, 1, 1);
    do_reset();
    for (int k = 0; k < 6; k++) idle(1, 1);
    chk("postrst_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
